// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and default widths for the register-file write arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package reg_write_arbiter_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;

    typedef enum logic {
        ARB_NORMAL = 1'b0,
        ARB_FORCE  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Bundle of WB, MU, decode-hazard and register-file write signals.
// Latency: n/a (wiring only).
// Backpressure: wb_stall holds WB; mu_valid/mu_ready handshake for MU.
interface reg_write_arbiter_if
    import reg_write_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic                  wb_valid;
    logic [ADDR_WIDTH-1:0] wb_reg;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  wb_stall;
    logic                  mu_valid;
    logic                  mu_ready;
    logic [ADDR_WIDTH-1:0] mu_reg;
    logic [DATA_WIDTH-1:0] mu_data;
    logic [ADDR_WIDTH-1:0] rd_reg1;
    logic [ADDR_WIDTH-1:0] rd_reg2;
    logic                  rd_hazard1;
    logic                  rd_hazard2;
    logic                  rf_reg_write;
    logic [ADDR_WIDTH-1:0] rf_write_reg;
    logic [DATA_WIDTH-1:0] rf_write_data;

    modport slave (
        input  wb_valid, wb_reg, wb_data, mu_valid, mu_reg, mu_data, rd_reg1, rd_reg2,
        output wb_stall, mu_ready, rd_hazard1, rd_hazard2,
               rf_reg_write, rf_write_reg, rf_write_data
    );

    modport master (
        output wb_valid, wb_reg, wb_data, mu_valid, mu_reg, mu_data, rd_reg1, rd_reg2,
        input  wb_stall, mu_ready, rd_hazard1, rd_hazard2,
               rf_reg_write, rf_write_reg, rf_write_data
    );
endinterface

// File: rtl/reg_write_arbiter_mu_result_fifo.sv
// Synchronous FIFO of MU results {reg, data}, exposing per-entry valid/reg.
// Latency: 1 cycle from push to head visible.
// Backpressure: push ignored when full, pop ignored when empty.
module mu_result_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                push,
    input  logic [ADDR_WIDTH-1:0]               push_reg,
    input  logic [DATA_WIDTH-1:0]               push_data,
    input  logic                                pop,
    output logic                                full,
    output logic                                empty,
    output logic [ADDR_WIDTH-1:0]               head_reg,
    output logic [DATA_WIDTH-1:0]               head_data,
    output logic [DEPTH-1:0]                    ent_vld,
    output logic [DEPTH-1:0][ADDR_WIDTH-1:0]    ent_reg
);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0] dat;
    } ent_t;

    ent_t            mem_q [DEPTH];
    ent_t            mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW:0]     cnt_q, cnt_d;
    logic [DEPTH-1:0] vld_q, vld_d;
    logic            do_push, do_pop;

    assign full      = (cnt_q == (PW+1)'(DEPTH));
    assign empty     = (cnt_q == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_reg  = mem_q[rd_ptr_q].rd;
    assign head_data = mem_q[rd_ptr_q].dat;
    assign ent_vld   = vld_q;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_reg[i] = mem_q[i].rd;
        end
    end

    always_comb begin
        mem_d    = mem_q;
        vld_d    = vld_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = '{rd: push_reg, dat: push_data};
            vld_d[wr_ptr_q] = 1'b1;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + PW'(1);
        end
        // Simultaneous push and pop leaves the occupancy unchanged.
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (PW+1)'(1);
            2'b01:   cnt_d = cnt_q - (PW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (!rst_n) begin
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: rtl/reg_write_arbiter.sv
// Arbitrates the register-file write port between WB and buffered MU results.
// Latency: 1 cycle from grant to rf_* outputs.
// Backpressure: wb_stall holds WB during forced FIFO grants; mu_ready = !fifo_full.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    reg_write_arbiter_if.slave   bus
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    arb_state_e                           state_q, state_d;
    logic [CW-1:0]                        cnt_q, cnt_d;
    logic                                 rf_we_q, rf_we_d;
    logic [ADDR_WIDTH-1:0]                rf_reg_q, rf_reg_d;
    logic [DATA_WIDTH-1:0]                rf_dat_q, rf_dat_d;
    logic                                 grant_wb, grant_fifo, wb_stall;
    logic                                 fifo_full, fifo_empty, fifo_push;
    logic [ADDR_WIDTH-1:0]                head_reg;
    logic [DATA_WIDTH-1:0]                head_data;
    logic [FIFO_DEPTH-1:0]                ent_vld;
    logic [FIFO_DEPTH-1:0][ADDR_WIDTH-1:0] ent_reg;
    logic                                 mu_ready, hz1, hz2;

    assign mu_ready  = rst_n && !fifo_full;
    // Register-zero results complete the handshake but never occupy a slot.
    assign fifo_push = bus.mu_valid && mu_ready && (bus.mu_reg != '0);

    mu_result_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_reg  (bus.mu_reg),
        .push_data (bus.mu_data),
        .pop       (grant_fifo),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_reg  (head_reg),
        .head_data (head_data),
        .ent_vld   (ent_vld),
        .ent_reg   (ent_reg)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ARB_NORMAL;
            cnt_q    <= '0;
            rf_we_q  <= 1'b0;
            rf_reg_q <= '0;
            rf_dat_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rf_we_q  <= rf_we_d;
            rf_reg_q <= rf_reg_d;
            rf_dat_q <= rf_dat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            ARB_NORMAL: begin
                if (grant_wb && !fifo_empty) begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (cnt_d == CW'(STARVE_LIMIT)) begin
                    state_d = ARB_FORCE;
                end
            end
            default: state_d = ARB_NORMAL;
        endcase
    end

    always_comb begin
        grant_wb   = 1'b0;
        grant_fifo = 1'b0;
        wb_stall   = 1'b0;
        if (rst_n) begin
            case (state_q)
                ARB_NORMAL: begin
                    grant_wb   = bus.wb_valid;
                    grant_fifo = !bus.wb_valid && !fifo_empty;
                end
                default: begin
                    grant_fifo = !fifo_empty;
                    wb_stall   = bus.wb_valid;
                end
            endcase
        end
    end

    always_comb begin
        rf_we_d  = 1'b0;
        rf_reg_d = rf_reg_q;
        rf_dat_d = rf_dat_q;
        if (grant_wb) begin
            rf_we_d  = (bus.wb_reg != '0);
            rf_reg_d = bus.wb_reg;
            rf_dat_d = bus.wb_data;
        end else if (grant_fifo) begin
            rf_we_d  = 1'b1;
            rf_reg_d = head_reg;
            rf_dat_d = head_data;
        end
    end

    always_comb begin
        hz1 = 1'b0;
        hz2 = 1'b0;
        if (rst_n) begin
            if (rf_we_q && rf_reg_q == bus.rd_reg1) hz1 = 1'b1;
            if (rf_we_q && rf_reg_q == bus.rd_reg2) hz2 = 1'b1;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (ent_vld[i] && ent_reg[i] == bus.rd_reg1) hz1 = 1'b1;
                if (ent_vld[i] && ent_reg[i] == bus.rd_reg2) hz2 = 1'b1;
            end
            if (bus.rd_reg1 == '0) hz1 = 1'b0;
            if (bus.rd_reg2 == '0) hz2 = 1'b0;
        end
    end

    assign bus.mu_ready      = mu_ready;
    assign bus.wb_stall      = wb_stall;
    assign bus.rd_hazard1    = hz1;
    assign bus.rd_hazard2    = hz2;
    assign bus.rf_reg_write  = rf_we_q;
    assign bus.rf_write_reg  = rf_reg_q;
    assign bus.rf_write_data = rf_dat_q;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: table-driven WB vectors plus hand-written
// sequences, with committed writes checked against an expected-write queue.
module tb_reg_write_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    reg_write_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    reg_write_arbiter #(
        .DATA_WIDTH   (32),
        .ADDR_WIDTH   (5),
        .FIFO_DEPTH   (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } wr_t;
    wr_t exp_q [$];

    typedef struct {
        logic        wv;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic        hz;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [4:0] r, input logic [31:0] d);
        exp_q.push_back('{r: r, d: d});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every committed write must be the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.rf_reg_write === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got reg %0d data %0h required no write at %0t",
                         bus.rf_write_reg, bus.rf_write_data, $time);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("rf_write_reg", 32'(bus.rf_write_reg), 32'(e.r));
                chk("rf_write_data", bus.rf_write_data, e.d);
            end
        end
    end

    initial begin
        vecs[0] = '{1'b1, 5'd3,  32'h0000FFFF, 5'd3,  1'b1};
        vecs[1] = '{1'b1, 5'd0,  32'h0000DEAD, 5'd0,  1'b0};
        vecs[2] = '{1'b1, 5'd5,  32'h12345678, 5'd3,  1'b0};
        vecs[3] = '{1'b0, 5'd9,  32'hAAAAAAAA, 5'd5,  1'b0};
        vecs[4] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 1'b1};
        vecs[5] = '{1'b1, 5'd1,  32'h00000001, 5'd2,  1'b0};

        // Reset held two cycles with both producers active.
        rst_n = 1'b0;
        bus.wb_valid = 1'b1; bus.wb_reg = 5'd2; bus.wb_data = 32'h22222222;
        bus.mu_valid = 1'b1; bus.mu_reg = 5'd4; bus.mu_data = 32'h44444444;
        bus.rd_reg1 = 5'd4;  bus.rd_reg2 = 5'd2;
        tick();
        tick();
        chk("rst_reg_write", 32'(bus.rf_reg_write), 32'd0);
        chk("rst_mu_ready", 32'(bus.mu_ready), 32'd0);
        chk("rst_wb_stall", 32'(bus.wb_stall), 32'd0);
        chk("rst_hazard1", 32'(bus.rd_hazard1), 32'd0);
        chk("rst_write_reg", 32'(bus.rf_write_reg), 32'd0);
        chk("rst_write_data", bus.rf_write_data, 32'd0);
        rst_n = 1'b1;
        bus.mu_valid = 1'b0;
        #1;
        chk("post_rst_no_write", 32'(bus.rf_reg_write), 32'd0);
        chk("post_rst_mu_ready", 32'(bus.mu_ready), 32'd1);
        push_exp(5'd2, 32'h22222222);
        tick();
        bus.wb_valid = 1'b0;
        #1;
        chk("post_rst_hazard2", 32'(bus.rd_hazard2), 32'd1);
        bus.rd_reg2 = 5'd0;
        tick();

        // WB-only vectors.
        for (int i = 0; i < 6; i++) begin
            bus.wb_valid = vecs[i].wv;
            bus.wb_reg   = vecs[i].wr;
            bus.wb_data  = vecs[i].wd;
            if (vecs[i].wv && vecs[i].wr != 5'd0) push_exp(vecs[i].wr, vecs[i].wd);
            #1;
            chk("vec_wb_stall", 32'(bus.wb_stall), 32'd0);
            tick();
            bus.rd_reg1 = vecs[i].rd;
            #1;
            chk("vec_hazard1", 32'(bus.rd_hazard1), 32'(vecs[i].hz));
        end
        bus.wb_valid = 1'b0;
        tick();

        // Write-port outputs hold when nothing is granted.
        bus.wb_valid = 1'b1; bus.wb_reg = 5'd12; bus.wb_data = 32'hC0FFEE00;
        push_exp(5'd12, 32'hC0FFEE00);
        tick();
        bus.wb_valid = 1'b0;
        tick();
        chk("idle_reg_write", 32'(bus.rf_reg_write), 32'd0);
        chk("idle_hold_reg", 32'(bus.rf_write_reg), 32'd12);
        chk("idle_hold_data", bus.rf_write_data, 32'hC0FFEE00);

        // MU queueing: fill the FIFO behind WB traffic, then drain in order.
        bus.rd_reg1 = 5'd30; bus.rd_reg2 = 5'd31;
        bus.wb_valid = 1'b1; bus.wb_reg = 5'd10; bus.wb_data = 32'hA0000010;
        bus.mu_valid = 1'b1; bus.mu_reg = 5'd30; bus.mu_data = 32'hFFFF0000;
        push_exp(5'd10, 32'hA0000010);
        #1;
        chk("mu_ready_empty", 32'(bus.mu_ready), 32'd1);
        tick();
        bus.wb_reg = 5'd11; bus.wb_data = 32'hA0000011;
        bus.mu_reg = 5'd31; bus.mu_data = 32'h00000001;
        push_exp(5'd11, 32'hA0000011);
        #1;
        chk("mu_ready_one", 32'(bus.mu_ready), 32'd1);
        chk("mu_hz30_queued", 32'(bus.rd_hazard1), 32'd1);
        tick();
        chk("mu_ready_full", 32'(bus.mu_ready), 32'd0);
        chk("mu_hz31_queued", 32'(bus.rd_hazard2), 32'd1);
        bus.wb_valid = 1'b0; bus.mu_valid = 1'b0;
        push_exp(5'd30, 32'hFFFF0000);
        push_exp(5'd31, 32'h00000001);
        tick();
        chk("mu_hz30_outstage", 32'(bus.rd_hazard1), 32'd1);
        chk("mu_ready_drain", 32'(bus.mu_ready), 32'd1);
        tick();
        chk("mu_hz30_retired", 32'(bus.rd_hazard1), 32'd0);
        chk("mu_hz31_outstage", 32'(bus.rd_hazard2), 32'd1);
        tick();
        chk("mu_hz31_retired", 32'(bus.rd_hazard2), 32'd0);
        tick();

        // Starvation: reg 7 waits behind continuous WB traffic.
        bus.rd_reg1 = 5'd7; bus.rd_reg2 = 5'd0;
        bus.wb_valid = 1'b1; bus.wb_reg = 5'd20; bus.wb_data = 32'hB0000020;
        bus.mu_valid = 1'b1; bus.mu_reg = 5'd7;  bus.mu_data = 32'h77777777;
        push_exp(5'd20, 32'hB0000020);
        tick();
        bus.mu_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            bus.wb_reg  = 5'(20 + i);
            bus.wb_data = 32'hB0000020 + 32'(i);
            push_exp(5'(20 + i), 32'hB0000020 + 32'(i));
            #1;
            chk("starve_no_stall", 32'(bus.wb_stall), 32'd0);
            chk("starve_hz7", 32'(bus.rd_hazard1), 32'd1);
            tick();
        end
        bus.wb_reg = 5'd25; bus.wb_data = 32'hB0000025;
        #1;
        chk("starve_forced_stall", 32'(bus.wb_stall), 32'd1);
        push_exp(5'd7, 32'h77777777);
        tick();
        chk("starve_resume", 32'(bus.wb_stall), 32'd0);
        push_exp(5'd25, 32'hB0000025);
        tick();
        bus.wb_valid = 1'b0;
        tick();
        tick();

        // Register zero: MU reg-0 transfers take no FIFO slot, WB reg-0 never writes.
        bus.rd_reg1 = 5'd0;
        bus.wb_valid = 1'b1; bus.wb_reg = 5'd0; bus.wb_data = 32'h0BADF00D;
        bus.mu_valid = 1'b1; bus.mu_reg = 5'd0; bus.mu_data = 32'h0BADBEEF;
        #1;
        chk("zero_mu_ready0", 32'(bus.mu_ready), 32'd1);
        tick();
        tick();
        chk("zero_mu_ready2", 32'(bus.mu_ready), 32'd1);
        chk("zero_hazard1", 32'(bus.rd_hazard1), 32'd0);
        bus.mu_valid = 1'b0; bus.wb_valid = 1'b0;
        tick();
        tick();

        // Mid-operation reset with a full FIFO.
        bus.wb_valid = 1'b1; bus.wb_reg = 5'd14; bus.wb_data = 32'hC0000014;
        bus.mu_valid = 1'b1; bus.mu_reg = 5'd12; bus.mu_data = 32'hD0000012;
        push_exp(5'd14, 32'hC0000014);
        tick();
        bus.wb_reg = 5'd15; bus.wb_data = 32'hC0000015;
        bus.mu_reg = 5'd13; bus.mu_data = 32'hD0000013;
        push_exp(5'd15, 32'hC0000015);
        tick();
        bus.rd_reg1 = 5'd12; bus.rd_reg2 = 5'd13;
        #1;
        chk("midrst_full", 32'(bus.mu_ready), 32'd0);
        chk("midrst_hz1_before", 32'(bus.rd_hazard1), 32'd1);
        rst_n = 1'b0;
        bus.wb_valid = 1'b0; bus.mu_valid = 1'b0;
        #1;
        chk("midrst_hz1_in", 32'(bus.rd_hazard1), 32'd0);
        chk("midrst_hz2_in", 32'(bus.rd_hazard2), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("midrst_hz1_after", 32'(bus.rd_hazard1), 32'd0);
        chk("midrst_hz2_after", 32'(bus.rd_hazard2), 32'd0);
        chk("midrst_mu_ready", 32'(bus.mu_ready), 32'd1);
        for (int i = 0; i < 4; i++) tick();
        chk("midrst_hz1_late", 32'(bus.rd_hazard1), 32'd0);

        chk("writes_outstanding", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
